// File: rtl/proj_pkg.sv
// Shared constants, k-mer payload type and window-generator state encoding.
package proj_pkg;
  localparam int unsigned BASE_LEN    = 4;
  localparam int unsigned GENOME_BTYE = 2 * BASE_LEN;
  localparam int unsigned KMER_LEN    = 4;
  localparam int unsigned KMER_BASES  = 2 * KMER_LEN;
  localparam int unsigned KMER_POS_W  = 16;
  localparam int unsigned KMER_W      = KMER_LEN * GENOME_BTYE;
  localparam int unsigned FILL_W      = $clog2(KMER_BASES + 1);

  typedef logic [KMER_W-1:0] kmer_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2
  } kwg_state_e;
endpackage

// File: rtl/kmer_window_gen_if.sv
// Byte-in / k-mer-out handshake bundle between read loader, window generator and hasher.
interface kmer_window_gen_if
  import proj_pkg::*;
#(
  parameter int unsigned POS_W = KMER_POS_W
);
  logic                   in_valid;
  logic                   in_ready;
  logic [GENOME_BTYE-1:0] in_byte;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  kmer_t                  out_kmer;
  logic [POS_W-1:0]       out_pos;
  logic                   out_last;
  logic                   short_read;

  modport master (
    output in_valid, in_byte, in_last, out_ready,
    input  in_ready, out_valid, out_kmer, out_pos, out_last, short_read
  );

  modport slave (
    input  in_valid, in_byte, in_last, out_ready,
    output in_ready, out_valid, out_kmer, out_pos, out_last, short_read
  );
endinterface

// File: rtl/kmer_window_gen.sv
// Sliding-window k-mer extractor: one base shifted per cycle, one k-mer emitted per
// base once the window is full; window state is flushed at the end of each read.
module kmer_window_gen
  import proj_pkg::*;
#(
  parameter int unsigned POS_W = KMER_POS_W
) (
  input logic             clk,
  input logic             rst_n,
  kmer_window_gen_if.slave bus
);

  kwg_state_e             state_q, state_d;
  logic [GENOME_BTYE-1:0] byte_q, byte_d;
  logic                   last_q, last_d;
  kmer_t                  window_q, window_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [POS_W-1:0]       base_cnt_q, base_cnt_d;
  logic                   out_valid_q, out_valid_d;
  kmer_t                  out_kmer_q, out_kmer_d;
  logic [POS_W-1:0]       out_pos_q, out_pos_d;
  logic                   out_last_q, out_last_d;
  logic                   short_q, short_d;

  logic                   shift_en;
  logic                   in_ready_c;
  logic                   end_of_read;
  logic [BASE_LEN-1:0]    base;
  kmer_t                  window_shift;
  logic [FILL_W-1:0]      fill_post;

  // Datapath: pending base selection and the shifted window candidate.
  always_comb begin
    shift_en     = (state_q != S_IDLE) && (!out_valid_q || bus.out_ready);
    in_ready_c   = (state_q == S_IDLE) || ((state_q == S_LO) && shift_en);
    base         = (state_q == S_HI) ? byte_q[GENOME_BTYE-1 -: BASE_LEN]
                                     : byte_q[BASE_LEN-1:0];
    window_shift = {window_q[KMER_W-BASE_LEN-1:0], base};
    fill_post    = (fill_q == FILL_W'(KMER_BASES)) ? fill_q : fill_q + FILL_W'(1);
    end_of_read  = shift_en && (state_q == S_LO) && last_q;
  end

  // Next-state, window bookkeeping and registered k-mer outputs.
  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    last_d      = last_q;
    window_d    = window_q;
    fill_d      = fill_q;
    base_cnt_d  = base_cnt_q;
    out_valid_d = out_valid_q;
    out_kmer_d  = out_kmer_q;
    out_pos_d   = out_pos_q;
    out_last_d  = out_last_q;
    short_d     = 1'b0;

    case (state_q)
      S_IDLE: if (bus.in_valid) state_d = S_HI;
      S_HI:   if (shift_en) state_d = S_LO;
      S_LO:   if (shift_en) state_d = bus.in_valid ? S_HI : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bus.in_valid && in_ready_c) begin
      byte_d = bus.in_byte;
      last_d = bus.in_last;
    end

    if (shift_en) begin
      window_d   = window_shift;
      fill_d     = fill_post;
      base_cnt_d = base_cnt_q + POS_W'(1);
    end

    if (shift_en && (fill_post == FILL_W'(KMER_BASES))) begin
      out_valid_d = 1'b1;
      out_kmer_d  = window_shift;
      out_pos_d   = base_cnt_q - POS_W'(KMER_BASES - 1);
      out_last_d  = end_of_read;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // A read's last base flushes the window so the next read starts clean.
    if (end_of_read) begin
      window_d   = '0;
      fill_d     = '0;
      base_cnt_d = '0;
      short_d    = (fill_q < FILL_W'(KMER_BASES - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      byte_q      <= '0;
      last_q      <= 1'b0;
      window_q    <= '0;
      fill_q      <= '0;
      base_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_kmer_q  <= '0;
      out_pos_q   <= '0;
      out_last_q  <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      last_q      <= last_d;
      window_q    <= window_d;
      fill_q      <= fill_d;
      base_cnt_q  <= base_cnt_d;
      out_valid_q <= out_valid_d;
      out_kmer_q  <= out_kmer_d;
      out_pos_q   <= out_pos_d;
      out_last_q  <= out_last_d;
      short_q     <= short_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_kmer   = out_kmer_q;
  assign bus.out_pos    = out_pos_q;
  assign bus.out_last   = out_last_q;
  assign bus.short_read = short_q;

endmodule

// File: tb/tb_kmer_window_gen.sv
// Directed scoreboard bench for kmer_window_gen; a second instance with a 4-bit
// position counter shadows the main one to exercise position wrap.
module tb_kmer_window_gen;
  import proj_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kmer_window_gen_if #(.POS_W(16)) bus ();
  kmer_window_gen_if #(.POS_W(4))  bus_b ();

  assign bus_b.in_valid  = bus.in_valid;
  assign bus_b.in_byte   = bus.in_byte;
  assign bus_b.in_last   = bus.in_last;
  assign bus_b.out_ready = bus.out_ready;

  kmer_window_gen #(.POS_W(16)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  kmer_window_gen #(.POS_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  typedef struct {
    kmer_t       kmer;
    logic [15:0] pos;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   short_exp = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  bit   stall_chk = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: list every k-mer (or a short-read pulse) a read should produce.
  task automatic model_read(input logic [7:0] bytes[$]);
    logic [3:0] bases[$];
    kmer_t      k;
    exp_t       e;
    foreach (bytes[i]) begin
      bases.push_back(bytes[i][7:4]);
      bases.push_back(bytes[i][3:0]);
    end
    if (bases.size() < 8) short_exp++;
    for (int i = 7; i < bases.size(); i++) begin
      k = '0;
      for (int j = i - 7; j <= i; j++) k = {k[27:0], bases[j]};
      e.kmer = k;
      e.pos  = 16'(i - 7);
      e.last = (i == bases.size() - 1);
      sb.push_back(e);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int g = 0;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    bus.in_last  = last;
    do begin
      @(posedge clk);
      g++;
    end while (!bus.in_ready && g < 100);
    if (g >= 100) chk("accept_timeout", 64'(bus.in_ready), 64'd1);
    #1;
  endtask

  task automatic send_read(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i], i == bytes.size() - 1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while ((sb.size() != 0 || short_exp != 0) && g < 200) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    chk({tag, "_short_done"}, 64'(short_exp), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_out_kmer"}, 64'(bus.out_kmer), 64'd0);
    chk({tag, "_out_pos"}, 64'(bus.out_pos), 64'd0);
    chk({tag, "_out_last"}, 64'(bus.out_last), 64'd0);
    chk({tag, "_short_read"}, 64'(bus.short_read), 64'd0);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  // Monitor: compare each transferred k-mer against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.short_read) begin
        chk("short_read_expected", 64'(short_exp > 0), 64'd1);
        if (short_exp > 0) short_exp--;
      end
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_kmer", 64'(bus.out_valid), 64'd0);
        end else if (!bus.out_ready) begin
          chk("stall_kmer_hold", 64'(bus.out_kmer), 64'(sb[0].kmer));
          chk("stall_pos_hold", 64'(bus.out_pos), 64'(sb[0].pos));
          if (stall_chk) chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end else begin
          chk("kmer", 64'(bus.out_kmer), 64'(sb[0].kmer));
          chk("pos", 64'(bus.out_pos), 64'(sb[0].pos));
          chk("last", 64'(bus.out_last), 64'(sb[0].last));
          chk("b_valid", 64'(bus_b.out_valid), 64'd1);
          chk("b_kmer", 64'(bus_b.out_kmer), 64'(sb[0].kmer));
          chk("b_pos_wrap", 64'(bus_b.out_pos), 64'(sb[0].pos[3:0]));
          chk("b_last", 64'(bus_b.out_last), 64'(sb[0].last));
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [7:0] rd[$];
    logic [7:0] rd2[$];
    int g;

    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Exactly one k-mer from a 4-byte read
    rd = '{8'h12, 8'h34, 8'h56, 8'h78};
    model_read(rd);
    send_read(rd);
    drain("read4");

    // 5-byte read: three consecutive k-mers
    rd = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    model_read(rd);
    send_read(rd);
    drain("read5");

    // Same read with a 5-cycle stall after the first k-mer
    @(posedge clk);
    #1;
    model_read(rd);
    fork
      send_read(rd);
      begin
        g = 0;
        do begin
          @(posedge clk);
          g++;
        end while (!bus.out_valid && g < 100);
        #1;
        bus.out_ready = 1'b0;
        stall_chk = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        stall_chk = 1'b0;
      end
    join
    drain("stall");

    // Short read immediately followed by a full read
    rd  = '{8'h11, 8'h22, 8'h33};
    rd2 = '{8'hAB, 8'hCD, 8'hEF, 8'h01};
    model_read(rd);
    model_read(rd2);
    send_read(rd);
    send_read(rd2);
    drain("short_then_full");

    // Asynchronous reset mid-read, then a clean read
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    model_read(rd);
    send_read(rd);
    drain("after_reset");

    // 12-byte read: 17 k-mers, shadow instance wraps its 4-bit position
    rd = {};
    for (int i = 0; i < 12; i++) rd.push_back(8'($urandom));
    model_read(rd);
    send_read(rd);
    drain("wrap");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/kmer_window_gen.md
# kmer_window_gen

Streaming k-mer extractor directly upstream of the k-mer hasher. Accepts packed genome bytes (two bases per byte) from the read loader over a valid/ready handshake and keeps a sliding window of KMER_LEN bytes (2*KMER_LEN bases). Once per accepted base it emits the full window as one k-mer, tagged with its start position within the read, on a valid/ready handshake to the hasher. Reads are delimited by a last flag, and window state is flushed between reads.

## Interface
- Reset is asynchronous and active-low, on `rst_n`. The block uses a single clock, `clk`.
- BASE_LEN, 4: bits per base.
- GENOME_BTYE, 8: bits per input byte (2*BASE_LEN).
- KMER_LEN, 4: k-mer length in bytes; k-mer length in bases is KMER_BASES = 2*KMER_LEN = 8.
- POS_W, 16: width of the base-position counter.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input byte valid
- in_ready  out  1  block accepts a byte this cycle
- in_byte  in  GENOME_BTYE  two bases; [7:4] is the earlier base, [3:0] the later base
- in_last  in  1  byte is the final byte of the read
- out_valid  out  1  k-mer valid
- out_ready  in  1  hasher accepts the k-mer
- out_kmer  out  KMER_LEN*GENOME_BTYE  window; oldest base in MSBs, newest in LSBs
- out_pos  out  POS_W  read-relative index of the k-mer's first base, modulo 2^POS_W
- out_last  out  1  k-mer ends at the final base of the read
- short_read  out  1  one-cycle pulse: read ended before KMER_BASES bases were seen

## Operation
- FSM states:
  - S_IDLE: no byte held.
  - S_HI: the held byte's upper base is pending.
  - S_LO: the held byte's lower base is pending.
- Held state: the byte register and its last tag.
- shift_en = (state != S_IDLE) && (!out_valid || out_ready).
- On each shift:
  - window <= {window[W-BASE_LEN-1:0], base}, where W = KMER_LEN*GENOME_BTYE.
  - fill_cnt increments, saturating at KMER_BASES.
  - base_cnt increments, wrapping.
- Emission: if the post-shift fill_cnt equals KMER_BASES, register the outputs:
  - out_valid <= 1.
  - out_kmer <= new window.
  - out_pos <= base_cnt - (KMER_BASES-1), using the pre-increment base_cnt, wrapping.
  - out_last <= shifted base is the lower base of a last-tagged byte.
- No emission with out_ready high: out_valid <= 0. With out_valid high and out_ready low, all out_* hold.
- Transitions:
  - S_IDLE -> S_HI when in_valid is accepted.
  - S_HI -> S_LO on shift_en.
  - S_LO -> S_HI on shift_en with in_valid (new byte accepted the same cycle).
  - S_LO -> S_IDLE on shift_en without in_valid.
- in_ready = (state == S_IDLE) || (state == S_LO && shift_en). This is combinational; in_ready never depends on in_valid.
- End of read (lower base of a last-tagged byte shifted):
  - fill_cnt <= 0, base_cnt <= 0, window <= 0.
  - If the pre-shift fill_cnt < KMER_BASES-1, no k-mer is emitted and short_read pulses the next cycle.
- A last-tagged byte still contributes both of its bases.

## Timing
- Reset values: out_valid, out_kmer, out_pos, out_last and short_read are 0; state is S_IDLE, so in_ready = 1; window, fill_cnt and base_cnt are 0. Reset is asynchronous and takes effect mid-transfer; the in-flight byte and k-mer are discarded.
- Latency: byte accepted at edge N. The upper-base k-mer is valid in the cycle after edge N+1, and the lower-base k-mer one cycle later, given no backpressure.
- Throughput: 1 k-mer/cycle, 1 byte per 2 cycles.
- First k-mer of a read appears after the 8th base, i.e. after the 4th byte.
- Backpressure: no base is shifted while out_valid && !out_ready, and no base is dropped or duplicated.
- A last byte immediately followed by a new read's byte: the new read starts at pos 0 with an empty window. There is no bubble beyond the normal cadence.

## Structure
- Shared package (proj_pkg) holds:
  - KMER_BASES = 2*KMER_LEN.
  - KMER_POS_W.
  - typedef kmer_t as logic [KMER_LEN*GENOME_BTYE-1:0], shared with the hasher.
  - The kmer_window_gen state enum.
- Single module; no sub-module. The window shift register is inline.

## Test plan
- Bytes 0x12,0x34,0x56,0x78 (last on 0x78), out_ready=1 -> exactly one k-mer 0x12345678, pos 0, out_last=1; short_read stays 0.
- Bytes 0x12,0x34,0x56,0x78,0x9A (last on 0x9A) -> k-mers 0x12345678/pos 0, 0x23456789/pos 1, 0x3456789A/pos 2 with out_last=1, on consecutive cycles.
- Same 5-byte read with out_ready held low for 5 cycles after the first k-mer -> out_kmer/out_pos stable, in_ready=0 while stalled, same 3 k-mers in order, none lost or duplicated.
- Read 0x11,0x22,0x33 (last), then read 0xAB,0xCD,0xEF,0x01 (last) -> no k-mer and a 1-cycle short_read pulse for the first read; then a single k-mer 0xABCDEF01, pos 0, out_last=1.
- rst_n low for 1 cycle after 3 bytes of a read -> outputs return to reset values immediately; a following 4-byte read 0xDEADBEEF yields one k-mer 0xDEADBEEF at pos 0 with no stale bases.
- POS_W=4, 12-byte read with out_ready=1 -> 17 k-mers with out_pos 0..15 then 0 (wrap), out_last only on the final k-mer.
